// File: rtl/unified_mem_arbiter_pkg.sv
// Shared constants and types for the unified instruction/data memory arbiter.
//  - ARB_ST_*  : 2-bit FSM state encodings
//  - ARB_OWN_* : 1-bit transaction owner encodings
package unified_mem_arbiter_pkg;

    localparam logic [1:0] ARB_ST_IDLE = 2'd0;
    localparam logic [1:0] ARB_ST_REQ  = 2'd1;
    localparam logic [1:0] ARB_ST_RESP = 2'd2;

    localparam logic ARB_OWN_IF = 1'b0;
    localparam logic ARB_OWN_D  = 1'b1;

    typedef enum logic [1:0] {
        StIdle = ARB_ST_IDLE,
        StReq  = ARB_ST_REQ,
        StResp = ARB_ST_RESP
    } arb_state_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Fetch/data priority selector with starvation guard.
// Data wins when both ports request, except that after STARVE_LIMIT consecutive
// data grants made while a fetch was waiting, the fetch wins once.
//  clk_i, rst_i   : clock, synchronous active-high reset
//  if_req_i       : fetch port request
//  d_req_i        : data port request
//  grant_stb_i    : arbitration is being committed this cycle
//  grant_d_o      : data port would win now
//  grant_if_o     : fetch port would win now
module mem_arb_prio
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic grant_stb_i,
    output logic grant_d_o,
    output logic grant_if_o
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic            starved;

    assign starved = (starve_cnt_q == CntMax);

    always_comb begin
        grant_d_o  = 1'b0;
        grant_if_o = 1'b0;
        if (d_req_i && !(if_req_i && starved)) begin
            grant_d_o = 1'b1;
        end else if (if_req_i) begin
            grant_if_o = 1'b1;
        end
    end

    // Count only data grants that actually made a fetch wait.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_stb_i) begin
            if (grant_d_o && if_req_i) begin
                if (!starved) begin
                    starve_cnt_d = starve_cnt_q + CntOne;
                end
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the CPU fetch port
// and data port, one transaction at a time. Per-port ready pulses release core stalls.
//  clk_i, rst_i                     : clock, synchronous active-high reset
//  if_req_i/if_addr_i               : fetch request (level) and address
//  if_rdata_o/if_ready_o            : fetched word, valid with 1-cycle ready pulse
//  d_req_i/d_we_i/d_addr_i/d_wdata_i: data request, store flag, address, store data
//  d_rdata_o/d_ready_o              : load data (0 for stores), 1-cycle ready pulse
//  mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : memory request, held until mem_gnt_i
//  mem_gnt_i/mem_rvalid_i/mem_rdata_i        : memory accept, read-valid, read data
//  busy_o                           : a transaction is in flight
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              grant_stb, grant_d, grant_if;

    mem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_req_i   (if_req_i),
        .d_req_i    (d_req_i),
        .grant_stb_i(grant_stb),
        .grant_d_o  (grant_d),
        .grant_if_o (grant_if)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            owner_q <= ARB_OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        grant_stb  = 1'b0;
        if_ready_o = 1'b0;
        d_ready_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (if_req_i || d_req_i) begin
                    grant_stb = 1'b1;
                    owner_d   = grant_if ? ARB_OWN_IF : ARB_OWN_D;
                    we_d      = grant_d & d_we_i;
                    addr_d    = grant_if ? if_addr_i : d_addr_i;
                    wdata_d   = grant_d ? d_wdata_i : '0;
                    state_d   = StReq;
                end
            end
            StReq: begin
                if (mem_gnt_i) begin
                    // Stores complete on acceptance; a dropped request gets no pulse.
                    if (we_q) begin
                        d_ready_o = d_req_i;
                        state_d   = StIdle;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (mem_rvalid_i) begin
                    if (owner_q == ARB_OWN_IF) begin
                        if_ready_o = if_req_i;
                    end else begin
                        d_ready_o = d_req_i;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (rst_i) begin
            if_ready_o = 1'b0;
            d_ready_o  = 1'b0;
            grant_stb  = 1'b0;
        end
    end

    assign mem_req_o   = (state_q == StReq);
    assign mem_we_o    = mem_req_o & we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != StIdle);

    // Read data is exposed only alongside its ready pulse; store acks carry zero.
    assign if_rdata_o = if_ready_o ? mem_rdata_i : '0;
    assign d_rdata_o  = (d_ready_o && state_q == StResp) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_req, mem_we, busy;

    int total = 0;
    int bad   = 0;
    int streak = 0;
    logic [31:0] mem_model [logic [31:0]];
    bit won;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata),
        .if_ready_o  (if_ready),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_rdata_o   (d_rdata),
        .d_ready_o   (d_ready),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_gnt_i   (mem_gnt),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_if_ready"}, if_ready, 1'b0);
        chk1({tag, "_d_ready"}, d_ready, 1'b0);
        chk32({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk32({tag, "_d_rdata"}, d_rdata, 32'h0);
    endtask

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = 32'h1000 + ($urandom_range(0, 15) << 2);
    endtask

    task automatic new_d(input bit allow_store);
        d_req   = 1'b1;
        d_we    = allow_store ? 1'($urandom_range(0, 1)) : 1'b0;
        d_addr  = 32'h1000 + ($urandom_range(0, 15) << 2);
        d_wdata = $urandom;
    endtask

    // Called at a negedge with the IDLE-cycle requests already driven.
    // Ends just after sampling the cycle carrying the completion event.
    task automatic run_txn(input int gw, input int lat, input bit drop, input bit wiggle,
                           output bit won_if);
        bit          exp_if, ewe, gnt_now;
        logic [31:0] ea, ewd, rd;
        exp_if = (if_req && d_req) ? (streak == LIM) : if_req;
        if (!exp_if && if_req) streak = (streak < LIM) ? streak + 1 : LIM;
        else streak = 0;
        won_if = exp_if;
        ea  = exp_if ? if_addr : d_addr;
        ewe = !exp_if && d_we;
        ewd = d_wdata;
        rd  = 32'h0;
        #1;
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_mem_req", mem_req, 1'b0);
        chk_quiet("idle");
        @(negedge clk);
        gnt_now    = (gw == 0);
        mem_gnt    = gnt_now;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        if (gnt_now && ewe && drop) d_req = 1'b0;
        #1;
        chk1("req_mem_req", mem_req, 1'b1);
        chk32("req_addr", mem_addr, ea);
        chk1("req_we", mem_we, ewe);
        if (ewe) chk32("req_wdata", mem_wdata, ewd);
        for (int i = 0; i < gw; i++) begin
            chk_quiet("req_wait");
            @(negedge clk);
            gnt_now    = (i == gw - 1);
            mem_gnt    = gnt_now;
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            if (wiggle) begin
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            if (gnt_now && ewe && drop) d_req = 1'b0;
            #1;
            chk1("wait_mem_req", mem_req, 1'b1);
            chk32("wait_addr", mem_addr, ea);
            if (ewe) chk32("wait_wdata", mem_wdata, ewd);
        end
        if (ewe) begin
            chk1("st_d_ready", d_ready, !drop);
            chk1("st_if_ready", if_ready, 1'b0);
            chk32("st_d_rdata", d_rdata, 32'h0);
            mem_model[ea] = ewd;
        end else begin
            chk_quiet("gnt");
            for (int i = 0; i <= lat; i++) begin
                @(negedge clk);
                mem_gnt    = (i < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rvalid = (i == lat);
                rd         = mem_rd(ea);
                mem_rdata  = (i == lat) ? rd : $urandom;
                if (i == lat && drop) begin
                    if (exp_if) if_req = 1'b0;
                    else d_req = 1'b0;
                end
                #1;
                chk1("resp_mem_req", mem_req, 1'b0);
                chk1("resp_busy", busy, 1'b1);
                if (i < lat) chk_quiet("resp_wait");
            end
            chk1("ld_if_ready", if_ready, exp_if && !drop);
            chk1("ld_d_ready", d_ready, !exp_if && !drop);
            chk32("ld_if_rdata", if_rdata, (exp_if && !drop) ? rd : 32'h0);
            chk32("ld_d_rdata", d_rdata, (!exp_if && !drop) ? rd : 32'h0);
        end
    endtask

    // Next negedge: memory idle, the owner retires its request.
    task automatic finish_txn(input bit won_if);
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (won_if) if_req = 1'b0;
        else d_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk_quiet("rst");
        @(negedge clk);
        rst = 1'b0;

        // Fetch only, gnt immediately, rvalid two cycles after gnt.
        mem_model[32'h100] = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h100;
        run_txn(0, 1, 1'b0, 1'b0, won);
        chk1("t1_owner_if", won, 1'b1);
        finish_txn(won);

        // Store only: acked on the gnt cycle, no response phase.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h55;
        run_txn(0, 0, 1'b0, 1'b0, won);
        finish_txn(won);
        #1;
        chk1("t2_idle_after_store", busy, 1'b0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        run_txn(1, 2, 1'b0, 1'b0, won);
        finish_txn(won);

        // Both held as loads: D,D,D,D,IF repeating.
        new_if();
        new_d(1'b0);
        for (int k = 0; k < 10; k++) begin
            run_txn(0, 0, 1'b0, 1'b0, won);
            chk1("t3_order", won, (k % 5) == 4);
            finish_txn(won);
            if (won) new_if();
            else new_d(1'b0);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);

        // Fetch dropped before rvalid; then a normal load.
        if_req = 1'b1; if_addr = 32'h104;
        run_txn(0, 1, 1'b1, 1'b0, won);
        finish_txn(won);
        #1;
        chk1("t4_idle", busy, 1'b0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        run_txn(0, 0, 1'b0, 1'b0, won);
        chk1("t4_owner_d", won, 1'b0);
        finish_txn(won);

        // Reset while in RESP, late rvalid afterwards.
        if_req = 1'b1; if_addr = 32'h200;
        #1;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        chk1("t5_mem_req", mem_req, 1'b1);
        @(negedge clk);
        mem_gnt = 1'b0; rst = 1'b1; if_req = 1'b0;
        #1;
        chk_quiet("t5_rst_cycle");
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_mem_req", mem_req, 1'b0);
        chk1("t5_mem_we", mem_we, 1'b0);
        chk32("t5_mem_addr", mem_addr, 32'h0);
        chk32("t5_mem_wdata", mem_wdata, 32'h0);
        chk_quiet("t5_late_rvalid");
        streak = 0;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // gnt held off for 5 cycles while the requester's fields change.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2400; d_wdata = 32'h77;
        run_txn(5, 0, 1'b0, 1'b1, won);
        finish_txn(won);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2400;
        run_txn(0, 0, 1'b0, 1'b0, won);
        finish_txn(won);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 80; n++) begin
            if (!if_req && $urandom_range(0, 2) != 0) new_if();
            if (!d_req && $urandom_range(0, 2) != 0) new_d(1'b1);
            if (!if_req && !d_req) new_d(1'b1);
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    $urandom_range(0, 7) == 0, 1'b0, won);
            finish_txn(won);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
